// File: rtl/nth_root_engine_if.sv
// rtl/nth_root_engine_if.sv - operand/result handshake bundle for nth_root_engine
//
// Purpose: groups the operand and result valid/ready streams and the abort
//          control of the n-th root engine.
// Signals:
//   in_valid/in_ready    operand handshake
//   in_radicand [IN_W]   unsigned radicand
//   in_exp      [EXP_W]  exponent n
//   abort                synchronous cancel of the running operation
//   out_valid/out_ready  result handshake (result held until accepted)
//   out_root    [OUT_W]  floor(radicand^(1/n) * 2^FRAC_W)
//   out_exact            root^n equals the shifted radicand exactly
//   out_err              exponent out of range (0 or > MAX_EXP)
// Modports: master = operand producer / result consumer, slave = engine.
interface nth_root_engine_if #(
    parameter int IN_W    = 10,
    parameter int FRAC_W  = 10,
    parameter int MAX_EXP = 7
);
    localparam int EXP_W = $clog2(MAX_EXP + 1);
    localparam int OUT_W = IN_W + FRAC_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_radicand;
    logic [EXP_W-1:0] in_exp;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_root;
    logic             out_exact;
    logic             out_err;

    modport master (
        output in_valid, in_radicand, in_exp, abort, out_ready,
        input  in_ready, out_valid, out_root, out_exact, out_err
    );

    modport slave (
        input  in_valid, in_radicand, in_exp, abort, out_ready,
        output in_ready, out_valid, out_root, out_exact, out_err
    );
endinterface

// File: rtl/nth_root_engine.sv
// rtl/nth_root_engine.sv - bit-serial restoring n-th root engine
//
// Purpose: computes floor(radicand^(1/n) * 2^FRAC_W) by a restoring
//          digit-by-digit search, one root bit per n cycles, raising each
//          candidate to the n-th power with an iterative multiplier.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    nth_root_engine_if.slave (operand/result handshakes, abort)
module nth_root_engine #(
    parameter int IN_W    = 10,
    parameter int FRAC_W  = 10,
    parameter int MAX_EXP = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    nth_root_engine_if.slave   bus
);
    localparam int EXP_W = $clog2(MAX_EXP + 1);
    localparam int OUT_W = IN_W + FRAC_W;
    localparam int PW    = OUT_W * MAX_EXP;   // cand < 2^OUT_W, so cand^n fits
    localparam int KW    = $clog2(OUT_W);
    localparam logic [KW-1:0]    TOP_K   = KW'(OUT_W - 1);
    localparam logic [OUT_W-1:0] TOP_BIT = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_POW, S_CMP, S_DONE} state_t;

    state_t           r_state;
    logic [EXP_W-1:0] r_exp;
    logic [EXP_W-1:0] r_cnt;
    logic [KW-1:0]    r_k;
    logic [OUT_W-1:0] r_root;
    logic [OUT_W-1:0] r_cand;
    logic [PW-1:0]    r_p;
    logic [PW-1:0]    r_target;
    logic             r_exact;
    logic             r_err;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_root;
    logic             r_out_exact;
    logic             r_out_err;

    logic             w_exp_bad;
    logic [PW-1:0]    w_target;
    logic [PW-1:0]    w_mul;
    logic             w_lt;
    logic             w_eq;
    logic [OUT_W-1:0] w_root_next;
    logic [OUT_W-1:0] w_cand_next;

    assign w_exp_bad   = (bus.in_exp == '0) || (32'(bus.in_exp) > 32'(MAX_EXP));
    assign w_target    = PW'(bus.in_radicand) << (FRAC_W * bus.in_exp);
    assign w_mul       = r_p * PW'(r_cand);
    assign w_lt        = r_p < r_target;
    assign w_eq        = r_p == r_target;
    assign w_root_next = (w_lt || w_eq) ? r_cand : r_root;
    assign w_cand_next = w_root_next | (OUT_W'(1) << (r_k - 1'b1));

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_root  = r_out_root;
    assign bus.out_exact = r_out_exact;
    assign bus.out_err   = r_out_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_exp       <= '0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_root      <= '0;
            r_cand      <= '0;
            r_p         <= '0;
            r_target    <= '0;
            r_exact     <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_root  <= '0;
            r_out_exact <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (bus.abort && r_state != S_IDLE) begin
            // Discard the operation; the last delivered result stays visible.
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_exp      <= bus.in_exp;
                        r_target   <= w_target;
                        r_root     <= '0;
                        r_exact    <= 1'b0;
                        r_err      <= 1'b0;
                        r_k        <= TOP_K;
                        r_cand     <= TOP_BIT;
                        r_p        <= PW'(TOP_BIT);
                        r_cnt      <= bus.in_exp - 1'b1;
                        if (w_exp_bad) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (bus.in_radicand == '0) begin
                            r_exact <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= (bus.in_exp > EXP_W'(1)) ? S_POW : S_CMP;
                        end
                    end
                end
                S_POW: begin
                    r_p   <= w_mul;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == EXP_W'(1)) r_state <= S_CMP;
                end
                S_CMP: begin
                    r_root <= w_root_next;
                    if (w_eq) begin
                        // Exact root found: every lower bit would overshoot.
                        r_exact <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_k == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_k     <= r_k - 1'b1;
                        r_cand  <= w_cand_next;
                        r_p     <= PW'(w_cand_next);
                        r_cnt   <= r_exp - 1'b1;
                        r_state <= (r_exp > EXP_W'(1)) ? S_POW : S_CMP;
                    end
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        // Result register cycle: publish the finished result.
                        r_out_valid <= 1'b1;
                        r_out_root  <= r_root;
                        r_out_exact <= r_exact;
                        r_out_err   <= r_err;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nth_root_engine.sv
// tb/tb_nth_root_engine.sv - self-checking bench for nth_root_engine
module tb_nth_root_engine;
    localparam int IN_W    = 10;
    localparam int FRAC_W  = 10;
    localparam int MAX_EXP = 7;
    localparam int OUT_W   = IN_W + FRAC_W;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    nth_root_engine_if #(.IN_W(IN_W), .FRAC_W(FRAC_W), .MAX_EXP(MAX_EXP)) bus ();

    nth_root_engine #(.IN_W(IN_W), .FRAC_W(FRAC_W), .MAX_EXP(MAX_EXP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model: integer power and binary search for the largest r
    // with r^n <= radicand * 2^(FRAC_W*n).
    function automatic logic [191:0] pw(input longint c, input int e);
        logic [191:0] acc;
        acc = 192'd1;
        for (int i = 0; i < e; i++) acc = acc * 192'(c);
        return acc;
    endfunction

    function automatic longint ref_root(input int rad, input int e);
        logic [191:0] t;
        longint lo, hi, mid;
        t  = 192'(rad) << (FRAC_W * e);
        lo = 0;
        hi = longint'(1) << OUT_W;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (pw(mid, e) <= t) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    function automatic bit ref_exact(input int rad, input int e);
        return pw(ref_root(rad, e), e) == (192'(rad) << (FRAC_W * e));
    endfunction

    task automatic start_op(input int rad, input int e);
        int w;
        w = 0;
        while (!bus.in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_radicand = IN_W'(rad);
        bus.in_exp      = 3'(e);
        bus.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid    = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic full_op(input string tag, input int rad, input int e);
        int     lat;
        longint r;
        bit     ex, er;
        er = (e == 0);
        r  = er ? 0 : ref_root(rad, e);
        ex = er ? 1'b0 : ref_exact(rad, e);
        start_op(rad, e);
        wait_valid(lat);
        check({tag, "_root"},  32'(bus.out_root), 32'(r));
        check({tag, "_exact"}, 32'(bus.out_exact), 32'(ex));
        check({tag, "_err"},   32'(bus.out_err), 32'(er));
        if (er || rad == 0) check({tag, "_lat"}, 32'(lat), 32'd1);
        else if (!ex)       check({tag, "_lat"}, 32'(lat), 32'(OUT_W * e + 1));
        else                check({tag, "_lat_max"}, 32'(lat <= OUT_W * e + 1), 32'd1);
        finish_op();
    endtask

    initial begin
        int lat;
        logic [OUT_W-1:0] held_root;
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_radicand = '0;
        bus.in_exp      = '0;
        bus.abort       = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_root",  32'(bus.out_root), 32'd0);
        check("rst_out_exact", 32'(bus.out_exact), 32'd0);
        check("rst_out_err",   32'(bus.out_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with spec-given expected values
        start_op(27, 3);
        wait_valid(lat);
        check("cube27_root",  32'(bus.out_root), 32'h00C00);
        check("cube27_exact", 32'(bus.out_exact), 32'd1);
        check("cube27_err",   32'(bus.out_err), 32'd0);
        check("cube27_lat",   32'(lat <= 61), 32'd1);
        finish_op();

        start_op(2, 2);
        wait_valid(lat);
        check("sqrt2_root",  32'(bus.out_root), 32'd1448);
        check("sqrt2_exact", 32'(bus.out_exact), 32'd0);
        check("sqrt2_lat",   32'(lat), 32'd41);
        finish_op();

        start_op(1023, 1);
        wait_valid(lat);
        check("exp1_root",  32'(bus.out_root), 32'hFFC00);
        check("exp1_exact", 32'(bus.out_exact), 32'd1);
        check("exp1_lat",   32'(lat <= 21), 32'd1);
        finish_op();

        start_op(0, 5);
        wait_valid(lat);
        check("zero_root",  32'(bus.out_root), 32'd0);
        check("zero_exact", 32'(bus.out_exact), 32'd1);
        check("zero_lat",   32'(lat), 32'd1);
        finish_op();

        start_op(100, 0);
        wait_valid(lat);
        check("exp0_err",   32'(bus.out_err), 32'd1);
        check("exp0_root",  32'(bus.out_root), 32'd0);
        check("exp0_exact", 32'(bus.out_exact), 32'd0);
        check("exp0_lat",   32'(lat), 32'd1);
        finish_op();

        start_op(16, 4);
        wait_valid(lat);
        check("root4_root",  32'(bus.out_root), 32'h00800);
        check("root4_exact", 32'(bus.out_exact), 32'd1);
        check("root4_err",   32'(bus.out_err), 32'd0);
        finish_op();

        // Backpressure: result held, stray operands ignored
        start_op(27, 3);
        wait_valid(lat);
        held_root = bus.out_root;
        for (int i = 0; i < 5; i++) begin
            bus.in_radicand = 10'd5;
            bus.in_exp      = 3'd2;
            bus.in_valid    = 1'b1;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_root",  32'(bus.out_root), 32'(held_root));
            check("bp_in_ready",  32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        finish_op();
        check("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
        check("bp_valid_cleared",  32'(bus.out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_stray_op", 32'(bus.in_ready & ~bus.out_valid), 32'd1);

        // Abort during computation
        start_op(2, 2);
        repeat (9) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_in_ready",  32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) lat++;
        end
        check("abort_never_valid", 32'(lat), 32'd0);
        check("abort_root_kept",   32'(bus.out_root), 32'h00C00);

        // Asynchronous reset mid-computation
        start_op(1023, 1);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  32'(bus.in_ready), 32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_root",  32'(bus.out_root), 32'd0);
        check("arst_out_exact", 32'(bus.out_exact), 32'd0);
        check("arst_out_err",   32'(bus.out_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        full_op("post_rst", 2, 2);

        // Randomized operands against the reference model
        for (int i = 0; i < 14; i++) begin
            full_op("rand", int'($urandom_range(0, 1023)), int'($urandom_range(0, MAX_EXP)));
        end
        full_op("rand_max_exp", int'($urandom_range(1, 1023)), MAX_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
